// File: rtl/alu_arb_if.sv
// Bundle between the requesters, the round-robin ALU arbiter and the shared ALU.
// The slave view belongs to the arbiter; the master view belongs to the requesters and the ALU.
interface alu_arb_if #(
  parameter int NREQ = 4
);
  // Requester side
  logic [NREQ-1:0]    req;
  logic [NREQ*16-1:0] req_a;
  logic [NREQ*16-1:0] req_b;
  logic [NREQ*3-1:0]  req_func;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [15:0]        result;
  logic               busy;

  // ALU side
  logic               alu_en;
  logic [15:0]        alu_a;
  logic [15:0]        alu_b;
  logic [2:0]         alu_func;
  logic               alu_en_out;
  logic [15:0]        alu_out;

  modport slave (
    input  req, req_a, req_b, req_func, alu_en_out, alu_out,
    output gnt, done, result, busy, alu_en, alu_a, alu_b, alu_func
  );

  modport master (
    output req, req_a, req_b, req_func, alu_en_out, alu_out,
    input  gnt, done, result, busy, alu_en, alu_a, alu_b, alu_func
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered 16-bit ALU among NREQ requesters, one op in flight.
// Optional feature: define ALU_ARB_STATS_EN to add the op_cnt completed-operation counter port.
module alu_arbiter #(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic        clk,
  input  logic        rst,
  alu_arb_if.slave    bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0] op_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state;
  logic [IDXW-1:0]   rr_ptr;
  logic [IDXW-1:0]   owner;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   done_q;
  logic [15:0]       result_q;
  logic              busy_q;
  logic              alu_en_q;
  logic [15:0]       alu_a_q;
  logic [15:0]       alu_b_q;
  logic [2:0]        alu_func_q;

  logic [IDXW-1:0]   win_idx;
  logic [15:0]       win_a;
  logic [15:0]       win_b;
  logic [2:0]        win_func;
  int                scan_idx;

  // Scan from the highest offset down so the requester closest to rr_ptr wins last.
  // NOTE: every variable written here gets a value before any condition, so no latch is inferred.
  always_comb begin
    win_idx  = rr_ptr;
    scan_idx = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      if (bus.req[scan_idx]) win_idx = IDXW'(scan_idx);
    end
    win_a    = bus.req_a[16*int'(win_idx) +: 16];
    win_b    = bus.req_b[16*int'(win_idx) +: 16];
    win_func = bus.req_func[3*int'(win_idx) +: 3];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      alu_en_q   <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_func_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|bus.req) begin
            owner      <= win_idx;
            gnt_q      <= NREQ'(1) << win_idx;
            alu_a_q    <= win_a;
            alu_b_q    <= win_b;
            alu_func_q <= win_func;
            busy_q     <= 1'b1;
            alu_en_q   <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          gnt_q    <= '0;
          alu_en_q <= 1'b0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // No timeout: the ALU always answers one cycle after en_in.
          if (bus.alu_en_out) begin
            result_q <= bus.alu_out;
            done_q   <= NREQ'(1) << owner;
            state    <= S_RESP;
          end
        end
        S_RESP: begin
          done_q <= '0;
          busy_q <= 1'b0;
          rr_ptr <= (owner == IDXW'(NREQ - 1)) ? '0 : owner + 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 op_cnt <= '0;
    else if (state == S_RESP) op_cnt <= op_cnt + 16'd1;
  end
`endif

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.busy     = busy_q;
  assign bus.alu_en   = alu_en_q;
  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.alu_func = alu_func_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural one-cycle registered ALU.
// Timeline per op: request sampled at edge E0, gnt/alu_en in the following cycle, done two cycles after gnt.
module tb_alu_arbiter;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  alu_arb_if #(.NREQ(NREQ)) bus ();

`ifdef ALU_ARB_STATS_EN
  logic [15:0] op_cnt;
`endif

  alu_arbiter #(.NREQ(NREQ), .IDXW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ALU_ARB_STATS_EN
    ,
    .op_cnt (op_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Function map of the bench ALU: and, add, sub, or, not, shl, shr, xor.
  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] f);
    case (f)
      3'd0:    return a & b;
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return a | b;
      3'd4:    return ~a;
      3'd5:    return a << b[3:0];
      3'd6:    return a >> b[3:0];
      default: return a ^ b;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.alu_en_out <= 1'b0;
      bus.alu_out    <= '0;
    end else begin
      bus.alu_en_out <= bus.alu_en;
      bus.alu_out    <= alu_f(bus.alu_a, bus.alu_b, bus.alu_func);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] f);
    bus.req_a[16*i +: 16] = a;
    bus.req_b[16*i +: 16] = b;
    bus.req_func[3*i +: 3] = f;
  endtask

  task automatic wait_gnt(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bus.gnt != '0) begin
        n  = c;
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic do_reset;
    bus.req = '0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    bus.req      = 4'b1111;
    bus.req_a    = '0;
    bus.req_b    = '0;
    bus.req_func = '0;
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.gnt !== 4'b0000 || bus.done !== 4'b0000) begin
      errors++;
      $display("FAIL reset_gnt_done got gnt=%b done=%b exp 0000/0000", bus.gnt, bus.done);
    end
    checks++;
    if (bus.result !== 16'h0 || bus.busy !== 1'b0 || bus.alu_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_result_busy_en got %h/%b/%b exp 0000/0/0", bus.result, bus.busy, bus.alu_en);
    end
    checks++;
    if (bus.alu_a !== 16'h0 || bus.alu_b !== 16'h0 || bus.alu_func !== 3'd0) begin
      errors++;
      $display("FAIL reset_alu_bus got a=%h b=%h f=%0d exp 0/0/0", bus.alu_a, bus.alu_b, bus.alu_func);
    end
`ifdef ALU_ARB_STATS_EN
    checks++;
    if (op_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_op_cnt got %0d exp 0", op_cnt);
    end
`endif
    bus.req = '0;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req got gnt=%b busy=%b exp 0000/0", bus.gnt, bus.busy);
    end
  endtask

  task automatic test_single_op;
    int n;
    bit ok;
    set_op(0, 16'd3, 16'd5, 3'b001);
    bus.req = 4'b0001;
    wait_gnt(n, ok);
    checks++;
    if (!ok || n != 1 || bus.gnt !== 4'b0001) begin
      errors++;
      $display("FAIL single_gnt got gnt=%b after %0d cycles exp 0001 after 1", bus.gnt, n);
    end
    checks++;
    if (bus.alu_en !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 4'b0000) begin
      errors++;
      $display("FAIL single_issue got en=%b busy=%b done=%b exp 1/1/0000", bus.alu_en, bus.busy, bus.done);
    end
    checks++;
    if (bus.alu_a !== 16'd3 || bus.alu_b !== 16'd5 || bus.alu_func !== 3'b001) begin
      errors++;
      $display("FAIL single_operands got a=%0d b=%0d f=%0d exp 3/5/1", bus.alu_a, bus.alu_b, bus.alu_func);
    end
    bus.req = '0;
    tick();
    checks++;
    if (bus.gnt !== 4'b0000 || bus.alu_en !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 4'b0000) begin
      errors++;
      $display("FAIL single_wait got gnt=%b en=%b busy=%b done=%b exp 0000/0/1/0000",
               bus.gnt, bus.alu_en, bus.busy, bus.done);
    end
    tick();
    checks++;
    if (bus.done !== 4'b0001 || bus.result !== 16'd8 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_done got done=%b result=%0d busy=%b exp 0001/8/1", bus.done, bus.result, bus.busy);
    end
    tick();
    checks++;
    if (bus.done !== 4'b0000 || bus.busy !== 1'b0 || bus.result !== 16'd8) begin
      errors++;
      $display("FAIL single_after got done=%b busy=%b result=%0d exp 0000/0/8", bus.done, bus.busy, bus.result);
    end
  endtask

  task automatic test_round_robin;
    int n;
    bit ok;
    logic [3:0] exp_gnt;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 16'(100 + i), 16'(i + 1), 3'b001);
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_gnt = 4'b0001 << (k % 4);
      wait_gnt(n, ok);
      checks++;
      if (!ok || bus.gnt !== exp_gnt || n != ((k == 0) ? 1 : 2)) begin
        errors++;
        $display("FAIL rr_gnt_%0d got gnt=%b wait=%0d exp %b wait=%0d", k, bus.gnt, n, exp_gnt,
                 (k == 0) ? 1 : 2);
      end
      tick();
      tick();
      checks++;
      if (bus.done !== exp_gnt || bus.result !== 16'(101 + 2 * (k % 4))) begin
        errors++;
        $display("FAIL rr_done_%0d got done=%b result=%0d exp %b/%0d", k, bus.done, bus.result,
                 exp_gnt, 101 + 2 * (k % 4));
      end
    end
    bus.req = '0;
    tick();
    tick();
  endtask

  task automatic test_wrap_and_shift;
    int n;
    bit ok;
    set_op(2, 16'h0001, 16'h0002, 3'b010);
    bus.req = 4'b0100;
    wait_gnt(n, ok);
    checks++;
    if (!ok || bus.gnt !== 4'b0100) begin
      errors++;
      $display("FAIL sub_gnt got %b exp 0100", bus.gnt);
    end
    bus.req = '0;
    tick();
    tick();
    checks++;
    if (bus.done !== 4'b0100 || bus.result !== 16'hFFFF) begin
      errors++;
      $display("FAIL sub_wrap got done=%b result=%h exp 0100/ffff", bus.done, bus.result);
    end
    tick();
    set_op(2, 16'h0001, 16'h0004, 3'b101);
    bus.req = 4'b0100;
    wait_gnt(n, ok);
    bus.req = '0;
    tick();
    tick();
    checks++;
    if (!ok || bus.done !== 4'b0100 || bus.result !== 16'h0010) begin
      errors++;
      $display("FAIL shl got done=%b result=%h exp 0100/0010", bus.done, bus.result);
    end
    tick();
  endtask

  task automatic test_reset_mid_op;
    int n;
    bit ok;
    bit saw_done;
    set_op(0, 16'd50, 16'd1, 3'b001);
    bus.req = 4'b0001;
    wait_gnt(n, ok);
    bus.req = '0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 4'b0000 || bus.result !== 16'h0 ||
        bus.alu_en !== 1'b0 || bus.alu_a !== 16'h0 || bus.gnt !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_async got busy=%b done=%b result=%h en=%b a=%h exp all zero",
               bus.busy, bus.done, bus.result, bus.alu_en, bus.alu_a);
    end
    tick();
    rst = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.done != '0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL rst_mid_no_done got a done pulse exp none");
    end
    set_op(3, 16'd20, 16'd22, 3'b001);
    bus.req = 4'b1000;
    wait_gnt(n, ok);
    checks++;
    if (!ok || n != 1 || bus.gnt !== 4'b1000) begin
      errors++;
      $display("FAIL rst_mid_regnt got gnt=%b wait=%0d exp 1000 wait=1", bus.gnt, n);
    end
    bus.req = '0;
    tick();
    tick();
    checks++;
    if (bus.done !== 4'b1000 || bus.result !== 16'd42) begin
      errors++;
      $display("FAIL rst_mid_result got done=%b result=%0d exp 1000/42", bus.done, bus.result);
    end
    tick();
  endtask

  task automatic test_operand_sampling;
    int n;
    bit ok;
    set_op(1, 16'd7, 16'd7, 3'b111);
    bus.req = 4'b0010;
    wait_gnt(n, ok);
    checks++;
    if (!ok || bus.gnt !== 4'b0010 || bus.alu_a !== 16'd7) begin
      errors++;
      $display("FAIL sample_gnt got gnt=%b a=%0d exp 0010/7", bus.gnt, bus.alu_a);
    end
    bus.req_a[16 +: 16] = 16'd9;
    bus.req = '0;
    tick();
    checks++;
    if (bus.alu_a !== 16'd7) begin
      errors++;
      $display("FAIL sample_hold got a=%0d exp 7", bus.alu_a);
    end
    tick();
    checks++;
    if (bus.done !== 4'b0010 || bus.result !== 16'h0000) begin
      errors++;
      $display("FAIL sample_result got done=%b result=%h exp 0010/0000", bus.done, bus.result);
    end
    tick();
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats;
    int n;
    bit ok;
    do_reset();
    set_op(0, 16'd1, 16'd1, 3'b001);
    for (int k = 0; k < 5; k++) begin
      bus.req = 4'b0001;
      wait_gnt(n, ok);
      bus.req = '0;
      tick();
      tick();
      tick();
    end
    checks++;
    if (op_cnt !== 16'd5) begin
      errors++;
      $display("FAIL stats_count got %0d exp 5", op_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_op();
    test_round_robin();
    test_wrap_and_shift();
    test_reset_mid_op();
    test_operand_sampling();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
